ff_wnd_scan_ctrl: RTL and testbench
===================================

// Module: ff_wnd_scan_ctrl
//
// PURPOSE
// Sequencer that finds the first set bit in a wide bitmap window, starting at an arbitrary
// offset and wrapping around the window end. It answers "next marked packet at or after index S".
// Each cycle it feeds one CHUNK_WIDTH slice of the latched window to a single ff_set instance,
// so one narrow priority tree serves the whole window. It sits between the transport state
// engine (requester) and the window bitmaps.
//
// PARAMETERS
// WND_SIZE         128  bitmap window width; integer multiple of CHUNK_WIDTH
// WND_IND_WIDTH    7    log2(WND_SIZE); width of window indexes
// CHUNK_WIDTH      32   slice width fed to ff_set per cycle; power of BLOCK_WIDTH
// CHUNK_IND_WIDTH  5    log2(CHUNK_WIDTH); ff_set VECT_IND_WIDTH
// BLOCK_WIDTH      2    ff_set tree radix
//
// PORTS
// clk         in   1              clock, all state on rising edge
// rst_n       in   1              synchronous reset, active low
// req_val     in   1              scan request valid
// req_rdy     out  1              controller can accept a request
// req_wnd     in   WND_SIZE       bitmap to scan; bit i = window index i
// req_start   in   WND_IND_WIDTH  first index searched
// resp_val    out  1              result valid
// resp_rdy    in   1              requester takes result
// resp_found  out  1              a set bit was found
// resp_ind    out  WND_IND_WIDTH  index of first set bit at or after req_start, wrapping
//
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): state=IDLE, req_rdy=0 during reset, resp_val=0, resp_found=0, resp_ind=0.
//   Reset mid-scan or mid-response drops the request silently; no response is issued.
// - NUM_CHUNKS=WND_SIZE/CHUNK_WIDTH. c0=req_start[WND_IND_WIDTH-1:CHUNK_IND_WIDTH], off=req_start[CHUNK_IND_WIDTH-1:0].
// - FSM IDLE -> SCAN -> RESP -> IDLE. req_rdy=1 only in IDLE; resp_val=1 only in RESP.
// - IDLE: on req_val&&req_rdy, latch req_wnd, c0, off; cur=c0; pass=0; go SCAN.
// - SCAN: one chunk per cycle, ff_set combinational on masked slice wnd[cur*CW +: CW]:
//     pass 0 (first visit of c0): bits < off masked to 0;
//     middle passes: unmasked;
//     final pass (second visit of c0, only when off!=0): bits >= off masked to 0.
//   Hit (val_out=1): resp_found<=1, resp_ind<={cur, ff_set ind_out}, go RESP.
//   Miss: cur<=cur+1 mod NUM_CHUNKS (wrap NUM_CHUNKS-1 -> 0), pass<=pass+1.
//   Last pass is pass NUM_CHUNKS-1 if off==0, else NUM_CHUNKS. Miss on last pass:
//   resp_found<=0, resp_ind<=0, go RESP.
// - Latency: hit on k-th scanned chunk (k>=1) gives resp_val=1 in the k+1-th cycle after
//   the accept edge. Worst case, empty window with off!=0: NUM_CHUNKS+1 scan cycles.
// - RESP: resp_val, resp_found, resp_ind held stable while resp_rdy=0. On resp_rdy=1:
//   go IDLE, resp_val=0 next cycle. No request is accepted in that same cycle.
//   Throughput: at most one request per (scan cycles + 2).
// - Window bits changing on req_wnd after accept have no effect (latched copy).
// - ff_set ind_out is used only when val_out=1.
// - All index arithmetic is unsigned, modulo WND_SIZE. cur counter is ceil(log2(NUM_CHUNKS)) bits.
//
// TESTING
// Defaults used; A = accept edge.
// 1. start=0, bit5 set -> found=1 ind=5, resp_val at A+2.
// 2. start=40, bits 10 and 100 set -> chunks 1,2,3 scanned -> found=1 ind=100, resp_val at A+4.
// 3. start=100, only bit 10 set (wrap) -> chunks 3,0 -> found=1 ind=10, resp_val at A+3.
// 4. start=40, only bit 35 set -> chunk1 pass0 masks bit 35; chunks 2,3,0, then final pass on
//    chunk1 (bits<8 kept) -> found=1 ind=35, resp_val at A+6.
// 5. Empty window: start=17 -> found=0 ind=0 at A+6. start=0 -> found=0 at A+5.
// 6. Hold resp_rdy=0 10 cycles -> outputs stable and req_rdy=0. Reset pulsed in SCAN ->
//    next cycle IDLE, resp_val=0, and a fresh request completes correctly.

Source files
------------

// File: rtl/ff_wnd_scan_ctrl.sv
// Wrapping first-set-bit search over a wide bitmap window, one chunk per cycle
// through a single narrow ff_set priority tree.

module ff_set #(
    parameter int unsigned VECT_WIDTH     = 32,
    parameter int unsigned VECT_IND_WIDTH = 5,
    parameter int unsigned BLOCK_WIDTH    = 2
) (
    input  logic [VECT_WIDTH-1:0]     vect_in,
    output logic                      val_out,
    output logic [VECT_IND_WIDTH-1:0] ind_out
);
    localparam int unsigned LEVELS = $clog2(VECT_WIDTH) / $clog2(BLOCK_WIDTH);

    logic                      v   [VECT_WIDTH];
    logic [VECT_IND_WIDTH-1:0] idx [VECT_WIDTH];
    logic                      nv;
    logic [VECT_IND_WIDTH-1:0] ni;

    // Radix-BLOCK_WIDTH reduction; each node keeps the lowest valid leaf index.
    always_comb begin
        nv = 1'b0;
        ni = '0;
        for (int i = 0; i < int'(VECT_WIDTH); i++) begin
            v[i]   = vect_in[i];
            idx[i] = VECT_IND_WIDTH'(i);
        end
        for (int l = 0; l < int'(LEVELS); l++) begin
            for (int g = 0; g < int'(VECT_WIDTH / BLOCK_WIDTH); g++) begin
                if (g < int'(VECT_WIDTH / (BLOCK_WIDTH ** (l + 1)))) begin
                    nv = 1'b0;
                    ni = '0;
                    for (int j = int'(BLOCK_WIDTH) - 1; j >= 0; j--) begin
                        if (v[g * int'(BLOCK_WIDTH) + j]) begin
                            nv = 1'b1;
                            ni = idx[g * int'(BLOCK_WIDTH) + j];
                        end
                    end
                    v[g]   = nv;
                    idx[g] = ni;
                end
            end
        end
        val_out = v[0];
        ind_out = idx[0];
    end
endmodule

module ff_wnd_scan_ctrl #(
    parameter int unsigned WND_SIZE        = 128,
    parameter int unsigned WND_IND_WIDTH   = 7,
    parameter int unsigned CHUNK_WIDTH     = 32,
    parameter int unsigned CHUNK_IND_WIDTH = 5,
    parameter int unsigned BLOCK_WIDTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic [WND_SIZE-1:0]      req_wnd,
    input  logic [WND_IND_WIDTH-1:0] req_start,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_found,
    output logic [WND_IND_WIDTH-1:0] resp_ind
);
    localparam int unsigned NUM_CHUNKS = WND_SIZE / CHUNK_WIDTH;
    localparam int unsigned CUR_W      = $clog2(NUM_CHUNKS);
    localparam int unsigned PASS_W     = $clog2(NUM_CHUNKS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                       state, state_nxt;
    logic [WND_SIZE-1:0]          wnd, wnd_nxt;
    logic [CUR_W-1:0]             cur, cur_nxt;
    logic [PASS_W-1:0]            pass, pass_nxt;
    logic [CHUNK_IND_WIDTH-1:0]   off, off_nxt;
    logic                         found_nxt, rdy_nxt, val_nxt;
    logic [WND_IND_WIDTH-1:0]     ind_nxt;
    logic [CHUNK_WIDTH-1:0]       slice, hi_mask, masked;
    logic                         last_pass, hit;
    logic [CHUNK_IND_WIDTH-1:0]   hit_ind;

    ff_set #(
        .VECT_WIDTH    (CHUNK_WIDTH),
        .VECT_IND_WIDTH(CHUNK_IND_WIDTH),
        .BLOCK_WIDTH   (BLOCK_WIDTH)
    ) u_ff_set (
        .vect_in(masked),
        .val_out(hit),
        .ind_out(hit_ind)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wnd        <= '0;
            cur        <= '0;
            pass       <= '0;
            off        <= '0;
            req_rdy    <= 1'b0;
            resp_val   <= 1'b0;
            resp_found <= 1'b0;
            resp_ind   <= '0;
        end else begin
            state      <= state_nxt;
            wnd        <= wnd_nxt;
            cur        <= cur_nxt;
            pass       <= pass_nxt;
            off        <= off_nxt;
            req_rdy    <= rdy_nxt;
            resp_val   <= val_nxt;
            resp_found <= found_nxt;
            resp_ind   <= ind_nxt;
        end
    end

    // First visit of the start chunk drops bits below off; the wrap-around revisit keeps only those.
    always_comb begin
        slice   = wnd[{cur, CHUNK_IND_WIDTH'(0)} +: CHUNK_WIDTH];
        hi_mask = {CHUNK_WIDTH{1'b1}} << off;
        if (pass == '0) begin
            masked = slice & hi_mask;
        end else if (pass == PASS_W'(NUM_CHUNKS)) begin
            masked = slice & ~hi_mask;
        end else begin
            masked = slice;
        end
        last_pass = (off == '0) ? (pass == PASS_W'(NUM_CHUNKS - 1))
                                : (pass == PASS_W'(NUM_CHUNKS));
    end

    always_comb begin
        state_nxt = state;
        wnd_nxt   = wnd;
        cur_nxt   = cur;
        pass_nxt  = pass;
        off_nxt   = off;
        found_nxt = resp_found;
        ind_nxt   = resp_ind;
        unique case (state)
            IDLE: begin
                if (req_val && req_rdy) begin
                    wnd_nxt   = req_wnd;
                    cur_nxt   = req_start[WND_IND_WIDTH-1:CHUNK_IND_WIDTH];
                    off_nxt   = req_start[CHUNK_IND_WIDTH-1:0];
                    pass_nxt  = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    found_nxt = 1'b1;
                    ind_nxt   = {cur, hit_ind};
                    state_nxt = RESP;
                end else if (last_pass) begin
                    found_nxt = 1'b0;
                    ind_nxt   = '0;
                    state_nxt = RESP;
                end else begin
                    cur_nxt  = (cur == CUR_W'(NUM_CHUNKS - 1)) ? '0 : cur + CUR_W'(1);
                    pass_nxt = pass + PASS_W'(1);
                end
            end
            RESP: begin
                if (resp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        rdy_nxt = (state_nxt == IDLE);
        val_nxt = (state_nxt == RESP);
    end
endmodule

// File: tb/tb_ff_wnd_scan_ctrl.sv
// Randomized bench for ff_wnd_scan_ctrl against a linear-search reference model.

module tb_ff_wnd_scan_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_val;
    logic         req_rdy;
    logic [127:0] req_wnd;
    logic [6:0]   req_start;
    logic         resp_val;
    logic         resp_rdy;
    logic         resp_found;
    logic [6:0]   resp_ind;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ff_wnd_scan_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_wnd   (req_wnd),
        .req_start (req_start),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_found(resp_found),
        .resp_ind  (resp_ind)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk indexes start, start+1, ... modulo 128; latency in edges after accept
    // equals the number of 32-bit chunks visited.
    function automatic void model(input logic [127:0] w, input int s,
                                  output bit f, output int ind, output int k);
        int c0, off;
        f   = 1'b0;
        ind = 0;
        for (int i = 0; i < 128; i++) begin
            if (!f && w[(s + i) % 128]) begin
                f   = 1'b1;
                ind = (s + i) % 128;
            end
        end
        c0  = s / 32;
        off = s % 32;
        if (!f)                          k = (off != 0) ? 5 : 4;
        else if (ind / 32 == c0 && ind < s) k = 5;
        else                             k = ((ind / 32 - c0 + 4) % 4) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [127:0] w, input int s, input int hold);
        bit   ef;
        int   ei, ek, n;
        logic sf;
        logic [6:0] si;
        model(w, s, ef, ei, ek);
        n = 0;
        while (!req_rdy && n < 20) begin
            tick();
            n++;
        end
        chk("req_rdy_wait", 32'(req_rdy), 32'd1);
        req_val   = 1'b1;
        req_wnd   = w;
        req_start = 7'(s);
        tick();
        req_val = 1'b0;
        req_wnd = {$urandom, $urandom, $urandom, $urandom};
        chk("rdy_low_scan", 32'(req_rdy), 32'd0);
        n = 0;
        while (!resp_val && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(ek));
        chk("found", 32'(resp_found), 32'(ef));
        chk("ind", 32'(resp_ind), 32'(ei));
        sf = resp_found;
        si = resp_ind;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_val", 32'(resp_val), 32'd1);
            chk("hold_stable", {24'd0, sf, si}, {24'd0, resp_found, resp_ind});
            chk("hold_rdy", 32'(req_rdy), 32'd0);
        end
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        chk("val_drop", 32'(resp_val), 32'd0);
        chk("rdy_back", 32'(req_rdy), 32'd1);
    endtask

    initial begin
        logic [127:0] w;
        rst_n     = 1'b0;
        req_val   = 1'b0;
        req_wnd   = '0;
        req_start = '0;
        resp_rdy  = 1'b0;
        tick();
        tick();
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        chk("rst_val", 32'(resp_val), 32'd0);
        chk("rst_found", 32'(resp_found), 32'd0);
        chk("rst_ind", 32'(resp_ind), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        w = '0; w[5] = 1'b1;                 do_req(w, 0, 10);
        w = '0; w[10] = 1'b1; w[100] = 1'b1; do_req(w, 40, 0);
        w = '0; w[10] = 1'b1;                do_req(w, 100, 1);
        w = '0; w[35] = 1'b1;                do_req(w, 40, 0);
        w = '0;                              do_req(w, 17, 0);
        w = '0;                              do_req(w, 0, 2);
        w = '0; w[127] = 1'b1;               do_req(w, 127, 0);
        w = '0; w[0] = 1'b1;                 do_req(w, 1, 0);

        // Reset while scanning drops the request
        w = '0;
        req_val   = 1'b1;
        req_wnd   = w;
        req_start = 7'd17;
        tick();
        req_val = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_val", 32'(resp_val), 32'd0);
        chk("midrst_rdy", 32'(req_rdy), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("midrst_noresp", 32'(resp_val), 32'd0);
        w = '0; w[64] = 1'b1;                do_req(w, 70, 0);

        // Random cases
        for (int t = 0; t < 60; t++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            w = '0;
            if (mode == 1) begin
                w[$urandom_range(0, 127)] = 1'b1;
            end else if (mode == 2) begin
                for (int b = 0; b < 3; b++) w[$urandom_range(0, 127)] = 1'b1;
            end else if (mode == 3) begin
                w = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
            end
            do_req(w, int'($urandom_range(0, 127)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
